// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants and store buffer drain states
package riscv_pkg;

   localparam int XLEN     = 32;
   localparam int SB_DEPTH = 4;

   typedef enum logic [1:0] {
      SB_IDLE  = 2'd0,
      SB_DRAIN = 2'd1,
      SB_DONE  = 2'd2
   } sb_state_e;

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store intake and data memory write channels of the store buffer
interface store_buffer_if #(
   parameter int XLEN = riscv_pkg::XLEN
);
   logic            st_valid_i;
   logic [XLEN-1:0] st_addr_i;
   logic [XLEN-1:0] st_data_i;
   logic            st_ready_o;
   logic            mem_valid_o;
   logic [XLEN-1:0] mem_addr_o;
   logic [XLEN-1:0] mem_data_o;
   logic            mem_ready_i;

   // store buffer side
   modport slave (
      input  st_valid_i, st_addr_i, st_data_i, mem_ready_i,
      output st_ready_o, mem_valid_o, mem_addr_o, mem_data_o
   );

   // core / memory side
   modport master (
      output st_valid_i, st_addr_i, st_data_i, mem_ready_i,
      input  st_ready_o, mem_valid_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/store_buffer_fwd.sv
// rtl/store_buffer_fwd.sv - load forwarding: word match against buffered stores, youngest wins
module store_buffer_fwd #(
   parameter int DEPTH = riscv_pkg::SB_DEPTH,
   parameter int XLEN  = riscv_pkg::XLEN
) (
   input  logic [DEPTH-1:0][XLEN-1:0] addr_i,
   input  logic [DEPTH-1:0][XLEN-1:0] data_i,
   input  logic [$clog2(DEPTH)-1:0]   rd_ptr_i,
   input  logic [$clog2(DEPTH):0]     count_i,
   input  logic [XLEN-1:0]            ld_addr_i,
   output logic                       hit_o,
   output logic [XLEN-1:0]            data_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] idx;
   logic          unused_byte_bits;

   // byte offset within the word does not take part in the match
   assign unused_byte_bits = ^{ld_addr_i[1:0], addr_i};

   // walk entries oldest to youngest so a later match overrides an earlier one
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = rd_ptr_i;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_i + PW'(i);
         if ((CW'(i) < count_i) && (addr_i[idx][XLEN-1:2] == ld_addr_i[XLEN-1:2])) begin
            hit_o  = 1'b1;
            data_o = data_i[idx];
         end
      end
   end
endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer with fence drain; load forwarding under STORE_BUF_FWD_EN
module store_buffer #(
   parameter int DEPTH = riscv_pkg::SB_DEPTH,
   parameter int XLEN  = riscv_pkg::XLEN
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   store_buffer_if.slave          sb,
   input  logic [XLEN-1:0]        ld_addr_i,
   output logic                   ld_hit_o,
   output logic [XLEN-1:0]        ld_data_o,
   input  logic                   drain_i,
   output logic                   drain_done_o,
   output logic [$clog2(DEPTH):0] count_o
);
   import riscv_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][XLEN-1:0] addr_q;
   logic [DEPTH-1:0][XLEN-1:0] data_q;
   logic [PW-1:0]              wr_ptr_q;
   logic [PW-1:0]              rd_ptr_q;
   logic [CW-1:0]              count_q;
   sb_state_e                  state_q;
   sb_state_e                  state_d;
   logic                       full;
   logic                       empty;
   logic                       push;
   logic                       pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // a full buffer never accepts, even if the head leaves this cycle
   assign sb.st_ready_o  = !full && (state_q == SB_IDLE);
   assign push           = sb.st_valid_i && sb.st_ready_o;
   assign sb.mem_valid_o = !empty;
   assign pop            = sb.mem_valid_o && sb.mem_ready_i;
   assign sb.mem_addr_o  = addr_q[rd_ptr_q];
   assign sb.mem_data_o  = data_q[rd_ptr_q];
   assign count_o        = count_q;

   // entry storage is not reset; occupancy alone decides what is valid
   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_q[wr_ptr_q] <= sb.st_addr_i;
         data_q[wr_ptr_q] <= sb.st_data_i;
      end
   end

   // pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // drain state register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= SB_IDLE;
      else         state_q <= state_d;
   end

   // drain sequencing: a fence waits for the buffer to empty, then pulses done
   always_comb begin
      state_d      = state_q;
      drain_done_o = 1'b0;
      case (state_q)
         SB_IDLE:  if (drain_i) state_d = SB_DRAIN;
         SB_DRAIN: if (empty && !push) state_d = SB_DONE;
         SB_DONE: begin
            drain_done_o = 1'b1;
            state_d      = SB_IDLE;
         end
         default:  state_d = SB_IDLE;
      endcase
   end

`ifdef STORE_BUF_FWD_EN
   store_buffer_fwd #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
   ) u_fwd (
      .addr_i    (addr_q),
      .data_i    (data_q),
      .rd_ptr_i  (rd_ptr_q),
      .count_i   (count_q),
      .ld_addr_i (ld_addr_i),
      .hit_o     (ld_hit_o),
      .data_o    (ld_data_o)
   );
`else
   logic unused_ld_addr;
   assign unused_ld_addr = ^ld_addr_i;
   assign ld_hit_o       = 1'b0;
   assign ld_data_o      = '0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;
`ifdef STORE_BUF_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk;
   logic        rstn;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        drain;
   logic        drain_done;
   logic [2:0]  count;
   int          vectors;
   int          miscompares;

   store_buffer_if sb_if ();

   store_buffer dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .sb           (sb_if),
      .ld_addr_i    (ld_addr),
      .ld_hit_o     (ld_hit),
      .ld_data_o    (ld_data),
      .drain_i      (drain),
      .drain_done_o (drain_done),
      .count_o      (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0; drain = 1'b0; ld_addr = '0;
      sb_if.st_valid_i = 1'b0; sb_if.st_addr_i = '0; sb_if.st_data_i = '0; sb_if.mem_ready_i = 1'b0;
      step(); step();
      vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
      vectors++; if (sb_if.mem_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_mem_valid got %b exp 0", sb_if.mem_valid_o); end
      rstn = 1'b1;
      step();
      vectors++; if (sb_if.st_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_st_ready got %b exp 1", sb_if.st_ready_o); end
      vectors++; if (drain_done !== 1'b0) begin miscompares++; $display("FAIL reset_drain_done got %b exp 0", drain_done); end
      vectors++; if (ld_hit !== 1'b0) begin miscompares++; $display("FAIL reset_ld_hit got %b exp 0", ld_hit); end
   endtask

   task automatic test_single();
      sb_if.st_valid_i = 1'b1; sb_if.st_addr_i = 32'h100; sb_if.st_data_i = 32'hDEADBEEF; sb_if.mem_ready_i = 1'b1;
      #1;
      vectors++; if (sb_if.mem_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_no_passthru got %b exp 0", sb_if.mem_valid_o); end
      step();
      sb_if.st_valid_i = 1'b0;
      #1;
      vectors++; if (sb_if.mem_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b exp 1", sb_if.mem_valid_o); end
      vectors++; if (sb_if.mem_addr_o !== 32'h100) begin miscompares++; $display("FAIL single_addr got %h exp 00000100", sb_if.mem_addr_o); end
      vectors++; if (sb_if.mem_data_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_data got %h exp deadbeef", sb_if.mem_data_o); end
      vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL single_count1 got %0d exp 1", count); end
      step();
      vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL single_count0 got %0d exp 0", count); end
      vectors++; if (sb_if.mem_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_idle got %b exp 0", sb_if.mem_valid_o); end
      sb_if.mem_ready_i = 1'b0;
   endtask

   task automatic test_full();
      sb_if.mem_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sb_if.st_valid_i = 1'b1; sb_if.st_addr_i = 32'h300 + 32'(4*i); sb_if.st_data_i = 32'hA0 + 32'(i);
         step();
      end
      sb_if.st_addr_i = 32'h999; sb_if.st_data_i = 32'h55;
      #1;
      vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_count got %0d exp 4", count); end
      vectors++; if (sb_if.st_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_st_ready got %b exp 0", sb_if.st_ready_o); end
      step();
      vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_held_count got %0d exp 4", count); end
      vectors++; if (sb_if.mem_addr_o !== 32'h300) begin miscompares++; $display("FAIL full_head_stable got %h exp 00000300", sb_if.mem_addr_o); end
      sb_if.st_valid_i = 1'b0; sb_if.mem_ready_i = 1'b1;
      step();
      sb_if.mem_ready_i = 1'b0;
      #1;
      vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL full_pop_count got %0d exp 3", count); end
      vectors++; if (sb_if.st_ready_o !== 1'b1) begin miscompares++; $display("FAIL full_pop_ready got %b exp 1", sb_if.st_ready_o); end
      vectors++; if (sb_if.mem_data_o !== 32'hA1) begin miscompares++; $display("FAIL full_next_head got %h exp 000000a1", sb_if.mem_data_o); end
      sb_if.mem_ready_i = 1'b1;
      step(); step(); step();
      sb_if.mem_ready_i = 1'b0;
      #1;
      vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL full_empty got %0d exp 0", count); end
   endtask

   task automatic test_back_to_back();
      sb_if.mem_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sb_if.st_valid_i = 1'b1; sb_if.st_addr_i = 32'h400 + 32'(4*i); sb_if.st_data_i = 32'hB0 + 32'(i);
         step();
      end
      sb_if.st_valid_i = 1'b0; sb_if.mem_ready_i = 1'b1;
      #1;
      vectors++; if (sb_if.mem_data_o !== 32'hB0) begin miscompares++; $display("FAIL b2b_first got %h exp 000000b0", sb_if.mem_data_o); end
      step();
      for (int k = 0; k < 8; k++) begin
         sb_if.st_valid_i = 1'b1; sb_if.st_addr_i = 32'h410 + 32'(4*k); sb_if.st_data_i = 32'hB4 + 32'(k);
         #1;
         vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL b2b_count[%0d] got %0d exp 3", k, count); end
         vectors++; if (sb_if.mem_data_o !== 32'hB1 + 32'(k)) begin miscompares++; $display("FAIL b2b_order[%0d] got %h exp %h", k, sb_if.mem_data_o, 32'hB1 + 32'(k)); end
         vectors++; if (sb_if.mem_addr_o !== 32'h404 + 32'(4*k)) begin miscompares++; $display("FAIL b2b_addr[%0d] got %h exp %h", k, sb_if.mem_addr_o, 32'h404 + 32'(4*k)); end
         step();
      end
      sb_if.st_valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         vectors++; if (sb_if.mem_data_o !== 32'hB9 + 32'(k)) begin miscompares++; $display("FAIL b2b_tail[%0d] got %h exp %h", k, sb_if.mem_data_o, 32'hB9 + 32'(k)); end
         step();
      end
      sb_if.mem_ready_i = 1'b0;
      #1;
      vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL b2b_empty got %0d exp 0", count); end
   endtask

   task automatic test_forward();
      logic        eh;
      logic [31:0] ed;
      sb_if.mem_ready_i = 1'b0; ld_addr = 32'h200;
      sb_if.st_valid_i = 1'b1; sb_if.st_addr_i = 32'h200; sb_if.st_data_i = 32'd1;
      #1;
      vectors++; if (ld_hit !== 1'b0) begin miscompares++; $display("FAIL fwd_same_cycle got %b exp 0", ld_hit); end
      step();
      sb_if.st_data_i = 32'd2;
      #1;
      eh = FWD; ed = FWD ? 32'd1 : 32'd0;
      vectors++; if (ld_hit !== eh || ld_data !== ed) begin miscompares++; $display("FAIL fwd_not_incoming got %b/%h exp %b/%h", ld_hit, ld_data, eh, ed); end
      step();
      sb_if.st_valid_i = 1'b0; ld_addr = 32'h202;
      #1;
      eh = FWD; ed = FWD ? 32'd2 : 32'd0;
      vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL fwd_no_coalesce got %0d exp 2", count); end
      vectors++; if (ld_hit !== eh || ld_data !== ed) begin miscompares++; $display("FAIL fwd_youngest got %b/%h exp %b/%h", ld_hit, ld_data, eh, ed); end
      ld_addr = 32'h204;
      #1;
      vectors++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin miscompares++; $display("FAIL fwd_miss got %b/%h exp 0/00000000", ld_hit, ld_data); end
      ld_addr = 32'h200; sb_if.mem_ready_i = 1'b1;
      #1;
      vectors++; if (sb_if.mem_data_o !== 32'd1) begin miscompares++; $display("FAIL fwd_head1 got %h exp 00000001", sb_if.mem_data_o); end
      step();
      #1;
      vectors++; if (sb_if.mem_data_o !== 32'd2) begin miscompares++; $display("FAIL fwd_head2 got %h exp 00000002", sb_if.mem_data_o); end
      vectors++; if (ld_hit !== eh || ld_data !== ed) begin miscompares++; $display("FAIL fwd_dequeuing_head got %b/%h exp %b/%h", ld_hit, ld_data, eh, ed); end
      step();
      sb_if.mem_ready_i = 1'b0;
      #1;
      vectors++; if (ld_hit !== 1'b0) begin miscompares++; $display("FAIL fwd_empty got %b exp 0", ld_hit); end
      ld_addr = '0;
   endtask

   task automatic test_drain();
      sb_if.mem_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sb_if.st_valid_i = 1'b1; sb_if.st_addr_i = 32'h500 + 32'(4*i); sb_if.st_data_i = 32'hC0 + 32'(i);
         step();
      end
      sb_if.st_valid_i = 1'b0; drain = 1'b1;
      step();
      drain = 1'b0; sb_if.mem_ready_i = 1'b1;
      #1;
      vectors++; if (sb_if.st_ready_o !== 1'b0 || count !== 3'd3) begin miscompares++; $display("FAIL drain_enter got rdy %b cnt %0d exp 0/3", sb_if.st_ready_o, count); end
      for (int k = 2; k >= 0; k--) begin
         step();
         vectors++; if (sb_if.st_ready_o !== 1'b0 || drain_done !== 1'b0 || count !== 3'(k)) begin miscompares++; $display("FAIL drain_wait[%0d] got rdy %b done %b cnt %0d exp 0/0/%0d", k, sb_if.st_ready_o, drain_done, count, k); end
      end
      step();
      vectors++; if (drain_done !== 1'b1 || sb_if.st_ready_o !== 1'b0) begin miscompares++; $display("FAIL drain_done got done %b rdy %b exp 1/0", drain_done, sb_if.st_ready_o); end
      step();
      vectors++; if (drain_done !== 1'b0 || sb_if.st_ready_o !== 1'b1) begin miscompares++; $display("FAIL drain_after got done %b rdy %b exp 0/1", drain_done, sb_if.st_ready_o); end
      sb_if.mem_ready_i = 1'b0; drain = 1'b1;
      step();
      drain = 1'b0;
      #1;
      vectors++; if (drain_done !== 1'b0 || sb_if.st_ready_o !== 1'b0) begin miscompares++; $display("FAIL drain_empty_state got done %b rdy %b exp 0/0", drain_done, sb_if.st_ready_o); end
      step();
      vectors++; if (drain_done !== 1'b1) begin miscompares++; $display("FAIL drain_empty_done got %b exp 1", drain_done); end
      step();
      vectors++; if (drain_done !== 1'b0 || sb_if.st_ready_o !== 1'b1) begin miscompares++; $display("FAIL drain_empty_after got done %b rdy %b exp 0/1", drain_done, sb_if.st_ready_o); end
   endtask

   task automatic test_reset_mid();
      sb_if.mem_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sb_if.st_valid_i = 1'b1; sb_if.st_addr_i = 32'h600 + 32'(4*i); sb_if.st_data_i = 32'hD0 + 32'(i);
         step();
      end
      sb_if.st_valid_i = 1'b0;
      #1;
      vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL rmid_pre got %0d exp 2", count); end
      rstn = 1'b0;
      #1;
      vectors++; if (sb_if.mem_valid_o !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL rmid_async got valid %b cnt %0d exp 0/0", sb_if.mem_valid_o, count); end
      step();
      rstn = 1'b1; sb_if.mem_ready_i = 1'b1;
      step();
      vectors++; if (sb_if.mem_valid_o !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL rmid_no_stale got valid %b cnt %0d exp 0/0", sb_if.mem_valid_o, count); end
      sb_if.mem_ready_i = 1'b0; sb_if.st_valid_i = 1'b1; sb_if.st_addr_i = 32'h700; sb_if.st_data_i = 32'hE0;
      step();
      sb_if.st_valid_i = 1'b0;
      #1;
      vectors++; if (sb_if.mem_data_o !== 32'hE0 || count !== 3'd1) begin miscompares++; $display("FAIL rmid_fresh got data %h cnt %0d exp 000000e0/1", sb_if.mem_data_o, count); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_single();
      test_full();
      test_back_to_back();
      test_forward();
      test_drain();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
